// File: rtl/pie_tx_engine_if.sv
`default_nettype none
// =============================================================================
// pie_tx_engine_if : data-bit stream into the PIE encoder (valid/ready + last)
// Rev 1.0
// =============================================================================
interface pie_tx_engine_if;
  logic in_dat;
  logic in_vld;
  logic in_last;
  logic in_rdy;

  modport master (output in_dat, output in_vld, output in_last, input in_rdy);
  modport slave  (input in_dat, input in_vld, input in_last, output in_rdy);
endinterface
`default_nettype wire

// File: rtl/pie_tx_engine.sv
`default_nettype none
// =============================================================================
// pie_tx_engine : run-time programmable PIE encoder (preamble / frame-sync + data)
// Rev 1.0
// =============================================================================
module pie_tx_engine #(
  parameter int   CNT_W      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] cfg_pw,
  input  logic [CNT_W-1:0] cfg_zero,
  input  logic [CNT_W-1:0] cfg_one,
  input  logic [CNT_W-1:0] cfg_rtcal,
  input  logic [CNT_W-1:0] cfg_trcal,
  input  logic [CNT_W-1:0] cfg_delim,
  pie_tx_engine_if.slave   dat_if,
  output logic             out_pie,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELIM = 3'd1,
    S_DATA0 = 3'd2,
    S_RTCAL = 3'd3,
    S_TRCAL = 3'd4,
    S_DATA  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pw_q, pw_d, zero_q, zero_d, one_q, one_d;
  logic [CNT_W-1:0] rtcal_q, rtcal_d, trcal_q, trcal_d, delim_q, delim_d;
  logic             mode_q, mode_d, bit_q, bit_d, last_q, last_d;
  logic             out_pie_q, out_pie_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             cfg_bad, sym_end, want_bit, in_rdy_c;
  logic [CNT_W-1:0] cur_len, nxt_len;

  // Every symbol must leave room for a high phase ahead of its pw low phase.
  assign cfg_bad = (cfg_pw == '0) || (cfg_zero <= cfg_pw) || (cfg_one <= cfg_pw) ||
                   (cfg_rtcal <= cfg_pw) || (mode && (cfg_trcal <= cfg_pw)) ||
                   (cfg_delim == '0);

  always_comb begin
    case (state_q)
      S_DELIM: cur_len = delim_q;
      S_DATA0: cur_len = zero_q;
      S_RTCAL: cur_len = rtcal_q;
      S_TRCAL: cur_len = trcal_q;
      S_DATA:  cur_len = bit_q ? one_q : zero_q;
      default: cur_len = '0;
    endcase
  end

  assign sym_end = (cnt_q == cur_len);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pw_d     = pw_q;
    zero_d   = zero_q;
    one_d    = one_q;
    rtcal_d  = rtcal_q;
    trcal_d  = trcal_q;
    delim_d  = delim_q;
    mode_d   = mode_q;
    bit_d    = bit_q;
    last_d   = last_q;
    err_d    = 1'b0;
    want_bit = 1'b0;
    in_rdy_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            pw_d    = cfg_pw;
            zero_d  = cfg_zero;
            one_d   = cfg_one;
            rtcal_d = cfg_rtcal;
            trcal_d = cfg_trcal;
            delim_d = cfg_delim;
            mode_d  = mode;
            state_d = S_DELIM;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_DELIM, S_DATA0, S_RTCAL, S_TRCAL, S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sym_end) begin
          cnt_d = CNT_W'(1);
          case (state_q)
            S_DELIM: state_d = S_DATA0;
            S_DATA0: state_d = S_RTCAL;
            S_RTCAL: begin
              if (mode_q) state_d = S_TRCAL;
              else        want_bit = 1'b1;
            end
            S_TRCAL: want_bit = 1'b1;
            default: begin
              if (last_q) begin
                state_d = S_FIN;
                cnt_d   = '0;
              end else begin
                want_bit = 1'b1;
              end
            end
          endcase
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // The accepted bit sizes the very next DATA symbol; no bit means underrun.
    if (want_bit) begin
      in_rdy_c = 1'b1;
      if (dat_if.in_vld) begin
        bit_d   = dat_if.in_dat;
        last_d  = dat_if.in_last;
        state_d = S_DATA;
      end else begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Output register follows the next position so out_pie lines up with state_q.
  always_comb begin
    case (state_d)
      S_DELIM: nxt_len = delim_d;
      S_DATA0: nxt_len = zero_d;
      S_RTCAL: nxt_len = rtcal_d;
      S_TRCAL: nxt_len = trcal_d;
      S_DATA:  nxt_len = bit_d ? one_d : zero_d;
      default: nxt_len = '0;
    endcase
    case (state_d)
      S_IDLE, S_FIN: out_pie_d = IDLE_LEVEL;
      S_DELIM:       out_pie_d = 1'b0;
      default:       out_pie_d = (cnt_d <= (nxt_len - pw_d));
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pw_q      <= '0;
      zero_q    <= '0;
      one_q     <= '0;
      rtcal_q   <= '0;
      trcal_q   <= '0;
      delim_q   <= '0;
      mode_q    <= 1'b0;
      bit_q     <= 1'b0;
      last_q    <= 1'b0;
      out_pie_q <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pw_q      <= pw_d;
      zero_q    <= zero_d;
      one_q     <= one_d;
      rtcal_q   <= rtcal_d;
      trcal_q   <= trcal_d;
      delim_q   <= delim_d;
      mode_q    <= mode_d;
      bit_q     <= bit_d;
      last_q    <= last_d;
      out_pie_q <= out_pie_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign dat_if.in_rdy = in_rdy_c;
  assign out_pie       = out_pie_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pie_tx_engine.sv
`default_nettype none
// =============================================================================
// tb_pie_tx_engine : scoreboard bench, expected per-cycle outputs queued up front
// Rev 1.0
// =============================================================================
module tb_pie_tx_engine;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, start, mode;
  logic [CNT_W-1:0] cfg_pw, cfg_zero, cfg_one, cfg_rtcal, cfg_trcal, cfg_delim;
  logic             out_pie, busy, done, err;

  pie_tx_engine_if u_if ();

  pie_tx_engine #(.CNT_W(CNT_W), .IDLE_LEVEL(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .cfg_pw    (cfg_pw),
    .cfg_zero  (cfg_zero),
    .cfg_one   (cfg_one),
    .cfg_rtcal (cfg_rtcal),
    .cfg_trcal (cfg_trcal),
    .cfg_delim (cfg_delim),
    .dat_if    (u_if),
    .out_pie   (out_pie),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic pie; logic bsy; logic dn; logic er; } exp_t;
  typedef struct packed { logic dat; logic last; } bit_t;

  exp_t sb[$];
  bit_t tx_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   rdy_cnt;

  function automatic void push(input logic p, input logic b, input logic d, input logic e);
    exp_t x;
    x.pie = p; x.bsy = b; x.dn = d; x.er = e;
    sb.push_back(x);
  endfunction

  function automatic void push_sym(input int len, input int pw);
    for (int k = 1; k <= len; k++) push(k <= len - pw, 1'b1, 1'b0, 1'b0);
  endfunction

  // Full frame model: delimiter, data-0, RTcal, optional TRcal, data bits, FIN.
  function automatic void push_frame(input logic md, input int pw, input int zero, input int one,
                                     input int rtcal, input int trcal, input int delim,
                                     input int nbits, input logic [7:0] bits);
    bit_t t;
    for (int k = 0; k < delim; k++) push(1'b0, 1'b1, 1'b0, 1'b0);
    push_sym(zero, pw);
    push_sym(rtcal, pw);
    if (md) push_sym(trcal, pw);
    for (int k = 0; k < nbits; k++) begin
      push_sym(bits[k] ? one : zero, pw);
      t.dat  = bits[k];
      t.last = (k == nbits - 1);
      tx_q.push_back(t);
    end
    push(1'b1, 1'b0, 1'b1, 1'b0);
  endfunction

  task automatic set_cfg(input logic md, input int pw, input int zero, input int one,
                         input int rtcal, input int trcal, input int delim);
    mode      = md;
    cfg_pw    = CNT_W'(pw);
    cfg_zero  = CNT_W'(zero);
    cfg_one   = CNT_W'(one);
    cfg_rtcal = CNT_W'(rtcal);
    cfg_trcal = CNT_W'(trcal);
    cfg_delim = CNT_W'(delim);
  endtask

  task automatic present();
    if (tx_q.size() > 0) begin
      u_if.in_vld  = 1'b1;
      u_if.in_dat  = tx_q[0].dat;
      u_if.in_last = tx_q[0].last;
    end else begin
      u_if.in_vld  = 1'b0;
      u_if.in_dat  = 1'b0;
      u_if.in_last = 1'b0;
    end
  endtask

  // Caller raises start; each cycle pops one expectation and compares outputs.
  task automatic run_sb(input string name, input int rst_at, input int restart_at, input bit scramble);
    bit   consumed;
    int   i;
    exp_t e;
    consumed = 1'b0;
    i        = 0;
    rdy_cnt  = 0;
    present();
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      rst = 1'b0;
      if (consumed) void'(tx_q.pop_front());
      if (i == 0) begin
        start = 1'b0;
        if (scramble) begin
          cfg_pw    = CNT_W'($urandom_range(0, 255));
          cfg_zero  = CNT_W'($urandom_range(0, 255));
          cfg_one   = CNT_W'($urandom_range(0, 255));
          cfg_rtcal = CNT_W'($urandom_range(0, 255));
          cfg_trcal = CNT_W'($urandom_range(0, 255));
          cfg_delim = CNT_W'($urandom_range(0, 255));
          mode      = ~mode;
        end
      end
      if (restart_at >= 0 && i == restart_at) begin
        start  = 1'b1;
        cfg_pw = CNT_W'(3);
      end
      if (restart_at >= 0 && i == restart_at + 2) start = 1'b0;
      present();
      e = sb.pop_front();
      n_vec++;
      if (out_pie !== e.pie) begin
        n_bad++;
        $display("FAIL %s out_pie cyc %0d: got %b want %b", name, i, out_pie, e.pie);
      end
      n_vec++;
      if (busy !== e.bsy) begin
        n_bad++;
        $display("FAIL %s busy cyc %0d: got %b want %b", name, i, busy, e.bsy);
      end
      n_vec++;
      if (done !== e.dn) begin
        n_bad++;
        $display("FAIL %s done cyc %0d: got %b want %b", name, i, done, e.dn);
      end
      n_vec++;
      if (err !== e.er) begin
        n_bad++;
        $display("FAIL %s err cyc %0d: got %b want %b", name, i, err, e.er);
      end
      consumed = (u_if.in_rdy === 1'b1) && u_if.in_vld;
      if (u_if.in_rdy === 1'b1) rdy_cnt++;
      if (i == rst_at) rst = 1'b1;
      i++;
    end
    start = 1'b0;
    rst   = 1'b0;
    tx_q.delete();
    present();
  endtask

  task automatic check_rdy(input string name, input int want);
    n_vec++;
    if (rdy_cnt != want) begin
      n_bad++;
      $display("FAIL %s in_rdy cycles: got %0d want %0d", name, rdy_cnt, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    set_cfg(1'b0, 2, 6, 10, 16, 32, 3);
    present();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if ({out_pie, busy, done, err, u_if.in_rdy} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset outputs {pie,busy,done,err,rdy}: got %b want 10000",
               {out_pie, busy, done, err, u_if.in_rdy});
    end
  endtask

  task automatic test_frame_sync(input string name);
    set_cfg(1'b0, 2, 6, 10, 16, 0, 3);
    push_frame(1'b0, 2, 6, 10, 16, 0, 3, 2, 8'b0000_0001);
    push(1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    run_sb(name, -1, -1, 1'b0);
    check_rdy(name, 2);
  endtask

  task automatic test_preamble();
    set_cfg(1'b1, 2, 6, 10, 16, 32, 3);
    push_frame(1'b1, 2, 6, 10, 16, 32, 3, 1, 8'b0000_0000);
    push(1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    run_sb("preamble", -1, -1, 1'b1);
    check_rdy("preamble", 1);
  endtask

  task automatic test_underrun();
    set_cfg(1'b1, 2, 6, 10, 16, 32, 3);
    for (int k = 0; k < 3; k++) push(1'b0, 1'b1, 1'b0, 1'b0);
    push_sym(6, 2);
    push_sym(16, 2);
    push_sym(32, 2);
    push(1'b1, 1'b0, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    run_sb("underrun", -1, -1, 1'b0);
    check_rdy("underrun", 1);
  endtask

  task automatic test_bad_cfg();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       set_cfg(1'b0, 2, 2, 10, 16, 32, 3);
        1:       set_cfg(1'b0, 0, 6, 10, 16, 32, 3);
        2:       set_cfg(1'b1, 2, 6, 10, 16, 2, 3);
        default: set_cfg(1'b0, 2, 6, 10, 16, 32, 0);
      endcase
      push(1'b1, 1'b0, 1'b0, 1'b1);
      push(1'b1, 1'b0, 1'b0, 1'b0);
      push(1'b1, 1'b0, 1'b0, 1'b0);
      start = 1'b1;
      run_sb($sformatf("bad_cfg%0d", c), -1, -1, 1'b0);
      check_rdy($sformatf("bad_cfg%0d", c), 0);
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(1'b0, 2, 6, 10, 16, 0, 3);
    push_frame(1'b0, 2, 6, 10, 16, 0, 3, 2, 8'b0000_0001);
    // Keep delimiter + data-0 + first 10 RTcal cycles, reset during the last of them.
    while (sb.size() > 19) void'(sb.pop_back());
    push(1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    run_sb("reset_mid", 18, -1, 1'b0);
    check_rdy("reset_mid", 0);
    test_frame_sync("after_reset");
  endtask

  task automatic test_back_to_back();
    set_cfg(1'b0, 2, 6, 10, 16, 0, 3);
    push_frame(1'b0, 2, 6, 10, 16, 0, 3, 1, 8'b0000_0000);
    push(1'b1, 1'b0, 1'b0, 1'b0);
    push_frame(1'b0, 3, 6, 10, 16, 0, 3, 1, 8'b0000_0001);
    push(1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    run_sb("back_to_back", -1, 31, 1'b0);
    check_rdy("back_to_back", 2);
  endtask

  task automatic test_random_bits();
    int          pw, zero, one, rtcal, delim, nbits;
    logic [7:0]  bits;
    for (int r = 0; r < 3; r++) begin
      pw    = $urandom_range(1, 3);
      zero  = pw + $urandom_range(1, 4);
      one   = zero + $urandom_range(1, 4);
      rtcal = one + $urandom_range(1, 4);
      delim = $urandom_range(1, 4);
      nbits = $urandom_range(3, 8);
      bits  = 8'($urandom_range(0, 255));
      set_cfg(1'b0, pw, zero, one, rtcal, 0, delim);
      push_frame(1'b0, pw, zero, one, rtcal, 0, delim, nbits, bits);
      push(1'b1, 1'b0, 1'b0, 1'b0);
      start = 1'b1;
      run_sb($sformatf("random%0d", r), -1, -1, 1'b0);
      check_rdy($sformatf("random%0d", r), nbits);
    end
  endtask

  initial begin
    test_reset();
    test_frame_sync("frame_sync");
    test_preamble();
    test_underrun();
    test_bad_cfg();
    test_reset_mid();
    test_back_to_back();
    test_random_bits();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
